// File: rtl/out_mem_ctrl.sv
// Output pixel memory sequencer: serialises vector stores into per-pixel writes
// and streams the full frame to the I/O dump path through a 1-cycle read pipeline.
module out_mem_ctrl #(
  parameter int WIDTH  = 24,
  parameter int PIXEL  = 8,
  parameter int LANES  = 4,
  parameter int BASE   = 90302,
  parameter int AMOUNT = 90000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vs_req,
  input  logic [WIDTH-1:0]       vs_addr,
  input  logic [LANES*PIXEL-1:0] vs_data,
  input  logic [LANES-1:0]       vs_mask,
  output logic                   vs_ack,
  input  logic                   io_start,
  output logic                   io_busy,
  output logic                   io_valid,
  output logic [PIXEL-1:0]       io_pixel,
  output logic [WIDTH-1:0]       io_index,
  output logic                   io_done,
  output logic                   mem_we,
  output logic [WIDTH-1:0]       mem_addr,
  output logic [PIXEL-1:0]       mem_wd,
  input  logic [WIDTH-1:0]       mem_rd
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [WIDTH-1:0]  BASE_A    = WIDTH'(BASE);
  localparam logic [WIDTH-1:0]  END_A     = WIDTH'(BASE + AMOUNT);
  localparam logic [WIDTH-1:0]  CNT_LAST  = WIDTH'(AMOUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_DUMP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic              io_pending_q, io_pending_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]  rd_idx_q, rd_idx_d;

  logic [WIDTH-1:0]       lane_addr;
  logic                   lane_in_range;
  logic [PIXEL-1:0]       lane_data;
  logic                   dumping;
  logic [WIDTH-PIXEL-1:0] rd_unused;

  // Wrapped lane addresses land below BASE and are therefore rejected here.
  assign lane_addr     = vs_addr + WIDTH'(lane_q);
  assign lane_in_range = (lane_addr >= BASE_A) && (lane_addr < END_A);
  assign dumping       = (state_q == S_DUMP) || (state_q == S_DRAIN) || (state_q == S_DONE);
  assign rd_unused     = mem_rd[WIDTH-1:PIXEL];

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) lane_data = vs_data[i*PIXEL +: PIXEL];
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    io_pending_d = io_pending_q | (io_start & ~dumping);
    rd_valid_d   = 1'b0;
    rd_idx_d     = rd_idx_q;
    vs_ack       = 1'b0;
    io_done      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wd       = '0;

    case (state_q)
      S_IDLE: begin
        if (vs_req) begin
          state_d = S_STORE;
          lane_d  = '0;
        end else if (io_pending_q) begin
          state_d = S_DUMP;
          cnt_d   = '0;
        end
      end
      S_STORE: begin
        mem_addr = lane_addr;
        mem_wd   = lane_data;
        mem_we   = vs_mask[lane_q] & lane_in_range;
        if (lane_q == LANE_LAST) begin
          vs_ack  = 1'b1;
          lane_d  = '0;
          state_d = S_IDLE;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      S_DUMP: begin
        mem_addr   = BASE_A + cnt_q;
        rd_valid_d = 1'b1;
        rd_idx_d   = cnt_q;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        io_done      = 1'b1;
        io_pending_d = 1'b0;
        cnt_d        = '0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data arrives one cycle after its address, so valid/index are delayed to match.
  assign io_valid = rd_valid_q;
  assign io_index = rd_valid_q ? rd_idx_q : '0;
  assign io_pixel = rd_valid_q ? mem_rd[PIXEL-1:0] : '0;
  assign io_busy  = io_pending_q | dumping;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      cnt_q        <= '0;
      io_pending_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      io_pending_q <= io_pending_d;
      rd_valid_q   <= rd_valid_d;
      rd_idx_q     <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_out_mem_ctrl.sv
// Directed bench for out_mem_ctrl with a behavioural output memory.
// The frame is shrunk to 1000 pixels so full dumps stay short; BASE is unchanged.
module tb_out_mem_ctrl;

  localparam int W      = 24;
  localparam int P      = 8;
  localparam int L      = 4;
  localparam int BASE   = 90302;
  localparam int AMOUNT = 1000;

  logic           clk;
  logic           reset;
  logic           vs_req;
  logic [W-1:0]   vs_addr;
  logic [L*P-1:0] vs_data;
  logic [L-1:0]   vs_mask;
  logic           vs_ack;
  logic           io_start;
  logic           io_busy;
  logic           io_valid;
  logic [P-1:0]   io_pixel;
  logic [W-1:0]   io_index;
  logic           io_done;
  logic           mem_we;
  logic [W-1:0]   mem_addr;
  logic [P-1:0]   mem_wd;
  logic [W-1:0]   mem_rd;

  out_mem_ctrl #(.WIDTH(W), .PIXEL(P), .LANES(L), .BASE(BASE), .AMOUNT(AMOUNT)) dut (
    .clk(clk), .reset(reset),
    .vs_req(vs_req), .vs_addr(vs_addr), .vs_data(vs_data), .vs_mask(vs_mask), .vs_ack(vs_ack),
    .io_start(io_start), .io_busy(io_busy), .io_valid(io_valid), .io_pixel(io_pixel),
    .io_index(io_index), .io_done(io_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [P-1:0] mem [AMOUNT];
  logic [P-1:0] exp_mem [AMOUNT];
  logic         minr;
  int           midx;
  int           wr_cnt;
  int           done_cnt;
  int           checks;
  int           failures;

  assign minr = (int'(mem_addr) >= BASE) && (int'(mem_addr) < BASE + AMOUNT);
  assign midx = minr ? (int'(mem_addr) - BASE) : 0;

  // Upper read-data bits are junk so only the pixel byte may reach io_pixel.
  always @(posedge clk) begin
    if (mem_we && minr) mem[midx] <= mem_wd;
    mem_rd <= minr ? {16'hA5A5, mem[midx]} : '0;
    if (mem_we) wr_cnt <= wr_cnt + 1;
    if (io_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input string tag, input logic [W-1:0] a, input logic [L*P-1:0] d,
                          input logic [L-1:0] m, input logic [L-1:0] exp_we, input int io_at);
    vs_req  = 1'b1;
    vs_addr = a;
    vs_data = d;
    vs_mask = m;
    for (int i = 0; i < L; i++) begin
      tick();
      io_start = (i == io_at);
      #1;
      chk(tag, {mem_we, mem_addr, vs_ack, io_busy},
          {exp_we[i], a + W'(i), (i == L - 1), (io_at >= 0 && i > io_at)});
      if (exp_we[i]) chk({tag, " wd"}, mem_wd, d[i*P +: P]);
    end
    tick();
    vs_req   = 1'b0;
    io_start = 1'b0;
    #1;
    chk({tag, " post"}, {vs_ack, mem_we}, 2'b00);
  endtask

  task automatic dump_frame(input int last, input bit with_req);
    tick();
    #1;
    chk("dump first", {mem_we, mem_addr, io_valid}, {1'b0, W'(BASE), 1'b0});
    for (int k = 0; k <= last; k++) begin
      tick();
      if (with_req && k == 300) begin
        vs_req  = 1'b1;
        vs_addr = W'(BASE + 20);
        vs_data = 32'hCCBBAA99;
        vs_mask = 4'hF;
      end
      io_start = with_req && (k == 400);
      #1;
      chk("dump pixel", {io_valid, io_index, io_pixel, vs_ack, io_done, io_busy, mem_we, mem_addr},
          {1'b1, W'(k), exp_mem[k], 1'b0, 1'b0, 1'b1, 1'b0,
           (k < AMOUNT - 1) ? W'(BASE + k + 1) : W'(0)});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    reset    = 1'b1;
    vs_req   = 1'b0;
    vs_addr  = '0;
    vs_data  = '0;
    vs_mask  = '0;
    io_start = 1'b0;
    for (int i = 0; i < AMOUNT; i++) begin
      mem[i]     <= P'(i * 7 + 3);
      exp_mem[i] = P'(i * 7 + 3);
    end

    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("idle outputs", {vs_ack, io_busy, io_valid, io_pixel, io_index, io_done, mem_we, mem_addr, mem_wd}, '0);
    end
    chk("idle no writes", wr_cnt, 0);

    do_store("store full", W'(BASE), 32'h44332211, 4'hF, 4'hF, -1);
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33; exp_mem[3] = 8'h44;

    do_store("store top edge", W'(BASE + AMOUNT - 2), 32'hD4C3B2A1, 4'b1011, 4'b0011, -1);
    exp_mem[AMOUNT-2] = 8'hA1; exp_mem[AMOUNT-1] = 8'hB2;

    do_store("store wrap", 24'hFFFFFE, 32'h01020304, 4'hF, 4'h0, -1);
    do_store("store masked", W'(BASE + 10), 32'hEEEEEEEE, 4'h0, 4'h0, -1);

    do_store("store io_start", W'(BASE + 4), 32'h88776655, 4'hF, 4'hF, 1);
    exp_mem[4] = 8'h55; exp_mem[5] = 8'h66; exp_mem[6] = 8'h77; exp_mem[7] = 8'h88;
    chk("writes after stores", wr_cnt, 10);
    chk("pending busy", io_busy, 1'b1);

    dump_frame(AMOUNT - 1, 1'b1);
    tick();
    #1;
    chk("dump done", {io_done, io_valid, io_busy, vs_ack, mem_we, mem_addr}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, W'(0)});
    tick();
    #1;
    chk("after done", {io_done, io_busy, vs_ack, io_valid}, 4'b0000);

    do_store("store after dump", W'(BASE + 20), 32'hCCBBAA99, 4'hF, 4'hF, -1);
    exp_mem[20] = 8'h99; exp_mem[21] = 8'hAA; exp_mem[22] = 8'hBB; exp_mem[23] = 8'hCC;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      chk("no second dump", {io_busy, io_valid, io_done}, 3'b000);
    end
    chk("one done pulse", done_cnt, 1);

    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    #1;
    chk("pending idle", {io_busy, mem_addr, io_valid}, {1'b1, W'(0), 1'b0});
    dump_frame(500, 1'b0);
    reset = 1'b1;
    tick();
    #1;
    chk("reset mid dump", {io_valid, io_busy, io_done, mem_we, mem_addr, io_index}, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("after abort", {io_valid, io_busy, io_done, mem_we, vs_ack}, 5'b00000);
    end
    chk("no done after abort", done_cnt, 1);
    chk("total writes", wr_cnt, 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
